// File: rtl/fifo_asr_pkg.sv
// Shared constants and helpers for the fifo_asr one-hot-pointer FIFO.
// Error-flag indices are used only when FIFO_ASR_ERR_EN is defined.
package fifo_asr_pkg;

    localparam int ERR_OVF = 0;
    localparam int ERR_UDF = 1;

    // Width of an occupancy counter that must hold 0..n inclusive.
    function automatic int level_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fifo_asr_if.sv
// Push/pop/flush bus and registered status of fifo_asr.
// The master drives requests; the slave (the FIFO) drives data and status.
interface fifo_asr_if #(
    parameter int W = 32,
    parameter int N = 16
);
    localparam int LW = fifo_asr_pkg::level_w(N);

    // A push is taken when push=1 and the FIFO is not full, or is full but a
    // pop is taken in the same cycle. A pop is taken when pop=1 and the FIFO
    // is not empty, which pop_data_valid reports. pop_data is show-ahead, and
    // flush overrides both requests.
    logic          flush;
    logic          push;
    logic [W-1:0]  push_data;
    logic          pop;
    logic          pop_data_valid;
    logic [W-1:0]  pop_data;
    logic          empty_r;
    logic          full_r;
    logic          almost_empty_r;
    logic          almost_full_r;
    logic [LW-1:0] level_r;
    logic          overflow_r;
    logic          underflow_r;

    modport master (
        output flush, push, push_data, pop,
        input  pop_data_valid, pop_data, empty_r, full_r,
               almost_empty_r, almost_full_r, level_r, overflow_r, underflow_r
    );

    modport slave (
        input  flush, push, push_data, pop,
        output pop_data_valid, pop_data, empty_r, full_r,
               almost_empty_r, almost_full_r, level_r, overflow_r, underflow_r
    );

endinterface

// File: rtl/fifo_asr_ptr.sv
// One-hot pointer register: returns to bit 0 on rst or clear, and rotates
// left by one position on each advance.
module fifo_asr_ptr #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         adv,
    output logic [N-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ptr <= N'(1);
        end else if (adv) begin
            ptr <= {ptr[N-2:0], ptr[N-1]};
        end
    end

endmodule

// File: rtl/fifo_asr.sv
// fifo_asr: single-clock show-ahead FIFO with one-hot pointers and registered status.
// Define FIFO_ASR_ERR_EN to enable sticky overflow/underflow flags.
module fifo_asr
    import fifo_asr_pkg::*;
#(
    parameter int W  = 32,
    parameter int N  = 16,
    parameter int AF = N - 2,
    parameter int AE = 1
) (
    input logic       clk,
    input logic       rst,
    fifo_asr_if.slave bus
);

    localparam int LW = level_w(N);
    localparam logic [LW-1:0] N_L  = LW'(N);
    localparam logic [LW-1:0] AF_L = LW'(AF);
    localparam logic [LW-1:0] AE_L = LW'(AE);

    generate
        if (N < 2 || AE >= AF) begin : g_bad_cfg
            $error("fifo_asr: illegal configuration (need N >= 2 and AE < AF)");
        end
    endgenerate

    logic [N-1:0]  wr_ptr;
    logic [N-1:0]  rd_ptr;
    logic          push_acc;
    logic          pop_acc;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_nxt;
    logic          empty_r;
    logic          full_r;
    logic          almost_empty_r;
    logic          almost_full_r;
    logic [W-1:0]  mem [N];
    logic [W-1:0]  head;

    // A full FIFO can still accept a push when the same cycle frees the head slot.
    assign pop_acc  = bus.pop & ~bus.flush & ~empty_r;
    assign push_acc = bus.push & ~bus.flush & (~full_r | pop_acc);

    fifo_asr_ptr #(.N(N)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.flush),
        .adv   (push_acc),
        .ptr   (wr_ptr)
    );

    fifo_asr_ptr #(.N(N)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.flush),
        .adv   (pop_acc),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push_acc && wr_ptr[i]) begin
                mem[i] <= bus.push_data;
            end
        end
    end

    always_comb begin
        head = '0;
        for (int i = 0; i < N; i++) begin
            if (rd_ptr[i]) begin
                head = head | mem[i];
            end
        end
    end

    always_comb begin
        if (bus.flush) begin
            level_nxt = '0;
        end else begin
            level_nxt = level_r + LW'(push_acc) - LW'(pop_acc);
        end
    end

    // Every status flag is registered from the next-state level, so all of
    // them change on the same edge as level_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_r        <= '0;
            empty_r        <= 1'b1;
            full_r         <= 1'b0;
            almost_empty_r <= 1'b1;
            almost_full_r  <= 1'b0;
        end else begin
            level_r        <= level_nxt;
            empty_r        <= (level_nxt == '0);
            full_r         <= (level_nxt == N_L);
            almost_empty_r <= (level_nxt <= AE_L);
            almost_full_r  <= (level_nxt >= AF_L);
        end
    end

`ifdef FIFO_ASR_ERR_EN
    logic [ERR_UDF:0] err_r;

    // Sticky until rst; flush deliberately leaves the flags alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= '0;
        end else begin
            if (bus.push && !bus.flush && full_r && !pop_acc) begin
                err_r[ERR_OVF] <= 1'b1;
            end
            if (bus.pop && !bus.flush && empty_r) begin
                err_r[ERR_UDF] <= 1'b1;
            end
        end
    end

    assign bus.overflow_r  = err_r[ERR_OVF];
    assign bus.underflow_r = err_r[ERR_UDF];
`else
    assign bus.overflow_r  = 1'b0;
    assign bus.underflow_r = 1'b0;
`endif

    assign bus.pop_data_valid = pop_acc;
    assign bus.pop_data       = empty_r ? '0 : head;
    assign bus.empty_r        = empty_r;
    assign bus.full_r         = full_r;
    assign bus.almost_empty_r = almost_empty_r;
    assign bus.almost_full_r  = almost_full_r;
    assign bus.level_r        = level_r;

endmodule

// File: doc/fifo_asr.md
FIFO_ASR -- requirements
Module: fifo_asr

Interface
REQ-001 Parameter W, default 32: data width in bits, legal range 1 or more.
REQ-002 Parameter N, default 16: depth in entries, legal range 2 or more.
REQ-003 Parameter AF, default N-2: almost-full threshold in entries, legal range 1..N.
REQ-004 Parameter AE, default 1: almost-empty threshold in entries, legal range 0..N-1.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset; synchronous and active-high.
REQ-007 flush  in  1  discard all contents this cycle.
REQ-008 push  in  1  write request.
REQ-009 push_data  in  W  write data.
REQ-010 pop  in  1  read request.
REQ-011 pop_data_valid  out  1  the pop is accepted this cycle.
REQ-012 pop_data  out  W  head entry, show-ahead, combinational from state.
REQ-013 empty_r, full_r, almost_empty_r, almost_full_r  out  1 each  registered status.
REQ-014 level_r  out  $clog2(N+1)  registered occupancy.
REQ-015 overflow_r, underflow_r  out  1 each  sticky error flags; see Configuration.

Function
REQ-016 Storage: N entries addressed by one-hot write and read pointers, each advancing by a rotate-left-by-1 on acceptance, wrapping from bit N-1 to bit 0.
REQ-017 push_acc = push & ~flush & (~full_r | pop_acc).
REQ-018 pop_acc = pop & ~flush & ~empty_r.
REQ-019 pop_data_valid = pop_acc; pop_data = the entry at the read pointer, 0 when empty_r.
REQ-020 Push and pop on an empty FIFO: push accepted, pop rejected; no bypass path.
REQ-021 Push and pop on a full FIFO: both accepted; level stays N; full_r stays 1.
REQ-022 level_nxt = level_r + push_acc - pop_acc; all status flags are registered from level_nxt.
REQ-023 empty_r = (level_nxt == 0); full_r = (level_nxt == N); almost_full_r = (level_nxt >= AF); almost_empty_r = (level_nxt <= AE).
REQ-024 Flush sets both pointers to one-hot bit 0 and level to 0 on the next edge; flush takes priority over push and pop in the same cycle; memory contents are not cleared.
REQ-025 A rejected push leaves memory, pointers and level unchanged.
REQ-026 Latency: data pushed at edge k is visible on pop_data from cycle k+1 once it reaches the head.

Reset
REQ-027 While rst is 1: pointers = one-hot bit 0, level_r = 0, empty_r = 1, full_r = 0, almost_empty_r = 1, almost_full_r = 0, overflow_r = 0, underflow_r = 0.
REQ-028 Memory has no reset; rst asserted mid-operation discards all contents the same way as flush.

Configuration
REQ-029 When macro FIFO_ASR_ERR_EN is defined: overflow_r sets on push & ~flush & full_r & ~pop_acc; underflow_r sets on pop & ~flush & empty_r; both clear only on rst, not on flush.
REQ-030 When FIFO_ASR_ERR_EN is undefined: overflow_r and underflow_r are tied to 0, no error flops exist, and all data-path behaviour is identical.

Structure
REQ-031 Package fifo_asr_pkg holds the level-width helper function (clog2 of N+1) and the error-flag index constants.
REQ-032 Sub-module fifo_asr_ptr is a one-hot pointer register with advance and clear inputs; it is instantiated once for write and once for read.
REQ-033 Elaboration fails if AE >= AF or N < 2.

Verification (W=8, N=4, AF=3, AE=1)
REQ-034 Push 0x11,0x22,0x33,0x44 -> level 1..4; almost_full_r at level 3; full_r at level 4; pops return 0x11..0x44 in order; empty_r=1 after the fourth pop.
REQ-035 At full, push 0x55 with no pop -> data dropped, level stays 4, overflow_r=1 (with FIFO_ASR_ERR_EN, else 0); next pop returns 0x11.
REQ-036 At full, push 0x55 and pop in the same cycle -> pop returns 0x11, level stays 4; drain yields 0x22,0x33,0x44,0x55 (wrap-around exercised).
REQ-037 When empty, push 0xA5 and pop in the same cycle -> pop_data_valid=0, level 1, underflow_r=1 (ERR_EN); next cycle pop_data=0xA5.
REQ-038 At level 3, flush asserted together with push -> next cycle level 0, empty_r=1, almost_empty_r=1; overflow_r and underflow_r unchanged.
REQ-039 rst asserted for one cycle at level 2 with errors set -> all outputs at their REQ-027 values; push 0x7E then pop returns 0x7E.
